// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx
// Receives 11-bit asynchronous serial frames: start bit, 8 data bits LSB first,
// an even-parity bit and a stop bit. Only accepted frames, with stop bit 1,
// update the outputs, and they then hold until the next accepted frame.
//
// Ports:
//   clk      system clock, rising edge
//   n_rst    asynchronous active-low reset
//   rx       serial line, asynchronous to clk, idle high
//   parity   1 when the received parity bit disagrees with even parity of the data
//   Rx_Data  data byte of the last accepted frame
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx,
  output logic       parity,
  output logic [7:0] Rx_Data
);

  // The counter never exceeds CLKS_PER_BIT-1, which always fits in clog2 bits.
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  // Even-parity of a data byte: 1 when the byte holds an odd number of ones.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic          sync1_r;
  logic          rxs;
  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    idx_r, idx_s;
  logic [7:0]    shift_r, shift_s;
  logic          pbit_r, pbit_s;
  logic [7:0]    data_s;
  logic          perr_s;

  // Two-flop synchronizer for the asynchronous rx line; resets to idle level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_r <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync1_r <= rx;
      rxs     <= sync1_r;
    end
  end

  // Frame state machine register and all datapath/output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      pbit_r  <= 1'b0;
      Rx_Data <= 8'h00;
      parity  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      pbit_r  <= pbit_s;
      Rx_Data <= data_s;
      parity  <= perr_s;
    end
  end

  // Next-state and next-value logic; every register holds unless a state acts.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    pbit_s  = pbit_r;
    data_s  = Rx_Data;
    perr_s  = parity;

    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        idx_s = 3'd0;
        if (!rxs) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end

      // Re-check the line at mid start bit so short low pulses are ignored.
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s = CNT_ZERO;
          if (!rxs) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s          = CNT_ZERO;
          shift_s[idx_r] = rxs;
          if (idx_r == 3'd7) begin
            idx_s   = 3'd0;
            state_s = PARITY;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      PARITY: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s   = CNT_ZERO;
          pbit_s  = rxs;
          state_s = STOP;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      // Byte and parity flag are committed together, only on a good stop bit.
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s = CNT_ZERO;
          if (rxs) begin
            data_s  = shift_r;
            perr_s  = pbit_r ^ even_parity(shift_r);
            state_s = IDLE;
          end else begin
            state_s = WAIT_HIGH;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      // After a framing error wait for the line to return high, so a held-low
      // break never looks like a new start bit.
      WAIT_HIGH: begin
        cnt_s = CNT_ZERO;
        if (rxs) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_HIGH;
        end
      end

      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        idx_s   = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx;
  logic       parity;
  logic [7:0] Rx_Data;

  always #10 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .rx      (rx),
    .parity  (parity),
    .Rx_Data (Rx_Data)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         due;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [8:0] last_model = 9'h000;
  bit         done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: accepted frame yields {parity bit XOR even parity of data, data}.
  function automatic logic [8:0] model(input logic [7:0] d, input logic pb);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return {pb ^ logic'(ones % 2), d};
  endfunction

  // Drive a frame from a negedge. Expected result queued only for good stop bit.
  // Start edge lands before edge cyc+1; t0 two edges later; stop sample at
  // t0 + C/2 + 10*C, visible at the following negedge.
  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
    exp_t e;
    if (sb) begin
      {e.perr, e.data} = model(d, pb);
      e.due = cyc + 3 + H + 10 * C;
      q.push_back(e);
      last_model = {e.perr, e.data};
    end
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (C) @(negedge clk);
    end
    rx = pb;
    repeat (C) @(negedge clk);
    rx = sb;
    repeat (C) @(negedge clk);
    if (sb) rx = 1'b1;
    else    rx = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any output change pops one expectation; none pending means unexpected.
  initial begin : monitor
    logic [8:0] prev;
    logic [8:0] cur;
    exp_t       e;
    prev = 9'h000;
    forever begin
      @(negedge clk);
      if (!done) begin
        cur = {parity, Rx_Data};
        if (!n_rst) begin
          check("reset_outputs", 32'(cur), 32'h0);
          prev = 9'h000;
        end else if (cur != prev) begin
          if (q.size() == 0) begin
            check("unexpected_change", 32'(cur), 32'(prev));
          end else begin
            e = q.pop_front();
            check("rx_data", 32'(Rx_Data), 32'(e.data));
            check("parity_err", 32'(parity), 32'(e.perr));
            check("latency", 32'(cyc), 32'(e.due));
          end
          prev = cur;
        end else if (q.size() > 0 && cyc > q[0].due) begin
          check("frame_timeout", 32'(cyc), 32'(q[0].due));
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    logic [7:0] d;
    logic       pb;
    int         kind;
    int         len;

    // Reset held while the line toggles.
    n_rst = 1'b0;
    rx    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rx = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    idle(50);

    // Glitches: 40 ns low every 100 ns, shorter than half a bit.
    for (int i = 0; i < 10; i++) begin
      rx = 1'b0;
      #40;
      rx = 1'b1;
      #60;
    end
    idle(20);
    check("glitch_hold", 32'({parity, Rx_Data}), 32'h0);

    // Directed frames.
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(5);
    send_frame(8'h01, 1'b0, 1'b1);
    idle(5);
    send_frame(8'h03, 1'b0, 1'b1);
    idle(5);

    // Framing error, line held low two bit times, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (2 * C) @(negedge clk);
    idle(10);
    check("framing_hold", 32'({parity, Rx_Data}), 32'h003);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(5);

    // Reset in the middle of data bit 4 of a 0xFF frame.
    rx = 1'b0;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    repeat (4 * C + H) @(negedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("midframe_reset", 32'({parity, Rx_Data}), 32'h0);
    last_model = 9'h000;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(5);

    // Randomized traffic: good frames, framing errors, glitches, 0..20 gaps.
    for (int n = 0; n < 14; n++) begin
      kind = $urandom_range(0, 9);
      d    = 8'($urandom_range(0, 255));
      pb   = 1'($urandom_range(0, 1));
      if (kind <= 6) begin
        while (model(d, pb) == last_model) d = 8'($urandom_range(0, 255));
        send_frame(d, pb, 1'b1);
      end else if (kind == 7) begin
        send_frame(d, pb, 1'b0);
        repeat ($urandom_range(1, 2 * C)) @(negedge clk);
        idle(6);
      end else begin
        len = $urandom_range(1, H - 1);
        rx  = 1'b0;
        repeat (len) @(negedge clk);
        idle(H + 6);
      end
      if ($urandom_range(0, 2) == 0) idle(0);
      else                           idle($urandom_range(1, 20));
    end

    idle(30);
    check("pending_frames", 32'(q.size()), 32'h0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that deserializes one 11-bit frame from the `rx` line: start bit, 8 data bits LSB first, even-parity bit, stop bit. It drives the received byte and a parity-error flag. It sits behind the board-level RX pin and feeds byte-oriented logic running on the system clock. Both outputs hold their value until the next valid frame completes.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 5208: system clocks per bit period (50 MHz / 9600 baud). Legal range is 4 or more.

Ports:
- `clk`: input, 1 bit. System clock; all logic is on the rising edge.
- `n_rst`: input, 1 bit. Reset, asynchronous and active-low.
- `rx`: input, 1 bit. Serial line, asynchronous to `clk`; idle high.
- `parity`: output, 1 bit. Parity-error flag for the last accepted frame. 1 means the received parity bit differs from the XOR of the 8 data bits (even parity).
- `Rx_Data`: output, 8 bits. Data byte of the last accepted frame.

## Operation
- `rx` passes through a 2-flop synchronizer that resets to 1. All decisions below use the synchronized value `rxs`.
- A bit-timing counter and a 3-bit data index are used. A shift register collects the data bits, LSB first.
- State machine:
  - IDLE: counter is cleared. On `rxs`==0, go to START.
  - START: count to `CLKS_PER_BIT/2 - 1` (integer division).
    - If `rxs`==0 at that sample, clear the counter and go to DATA.
    - If `rxs`==1, it was a glitch: return to IDLE with no output change.
  - DATA: count to `CLKS_PER_BIT - 1`, then sample `rxs` into bit[index] and clear the counter. After index 7, go to PARITY.
  - PARITY: after `CLKS_PER_BIT` cycles, sample the parity bit and go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample the stop bit.
    - Stop bit 1: load `Rx_Data` with the shift register and `parity` with (parity bit XOR ^data). Go to IDLE.
    - Stop bit 0 (framing error): discard the frame, leave outputs unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`==1, then go to IDLE. A break condition (line held low) never starts a new frame.
- Outputs change only on an accepted frame or on reset.
- Asserting `n_rst` at any time (including mid-frame) forces:
  - state IDLE
  - counters 0
  - synchronizer flops 1
  - `Rx_Data`=8'h00, `parity`=0

## Timing
- Reset values: `Rx_Data`=0, `parity`=0, state IDLE.
- Let t0 be the first clock edge at which IDLE sees `rxs`==0. This is 2 cycles after the `rx` falling edge.
- Sample points:
  - start bit: t0 + `CLKS_PER_BIT/2`
  - data bit i (0..7): t0 + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`
  - parity bit: t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`
  - stop bit: t0 + `CLKS_PER_BIT/2` + 10·`CLKS_PER_BIT`
- `Rx_Data` and `parity` become visible the cycle after the stop sample. They update together, never partially.
- A back-to-back frame is accepted when its start edge arrives any time after the stop sample. No idle gap beyond the stop bit is required.
- Pulses low for less than `CLKS_PER_BIT/2` cycles are rejected.

## Test plan
(All scenarios use `CLKS_PER_BIT`=16 and a 20 ns clock.)
- Reset: hold `n_rst`=0 with `rx` toggling → `Rx_Data`=8'h00, `parity`=0 throughout; no capture after release while `rx`=1.
- Valid frame 0xA5 with parity bit 0 and stop 1 → `Rx_Data`=8'hA5, `parity`=0, one cycle after the stop sample.
- Frame 0x01 with parity bit 0 (wrong) → `Rx_Data`=8'h01, `parity`=1. Then frame 0x03 with parity bit 0 → `Rx_Data`=8'h03, `parity`=0.
- Glitch filter: `rx` low for 40 ns pulses every 100 ns (shorter than half a bit) → outputs stay at 8'h00 / 0.
- Framing error: frame 0x3C with stop bit 0, then line held low for 2 bit times, then high → outputs keep their previous value. A following valid 0x5A frame yields `Rx_Data`=8'h5A.
- Mid-frame reset: assert `n_rst` during data bit 4 of a 0xFF frame → outputs 0 immediately. A clean 0x81 frame after release is received correctly.
